// File: rtl/game_pkg.sv
// Shared constants and encodings for the snake game-state logic.
package game_pkg;

   localparam int unsigned GRID_W   = 40;
   localparam int unsigned GRID_H   = 30;
   localparam int unsigned COORD_W  = 10;
   localparam int unsigned LEN_W    = 5;
   localparam int unsigned START_X  = 20;
   localparam int unsigned START_Y  = 15;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } play_state_t;

   // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
   localparam logic [1:0] DIR_OPP_MASK = 2'b01;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } cell_t;

   function automatic dir_t dir_opposite(input dir_t d);
      return dir_t'(2'(d) ^ DIR_OPP_MASK);
   endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Button priority, reversal rejection and pending/committed direction registers.
module snake_dir_latch
   import game_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic commit,
   input  logic reload,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   output dir_t pending,
   output dir_t committed,
   output logic any_btn_c
);

   dir_t req_c;

   assign any_btn_c = btn_up | btn_down | btn_left | btn_right;

   always_comb begin
      req_c = DIR_RIGHT;
      if (btn_up)        req_c = DIR_UP;
      else if (btn_down) req_c = DIR_DOWN;
      else if (btn_left) req_c = DIR_LEFT;
   end

   // Requests are checked against the committed direction as registered before this edge.
   always_ff @(posedge clk) begin
      if (rst || reload) begin
         pending   <= DIR_RIGHT;
         committed <= DIR_RIGHT;
      end else begin
         if (commit) committed <= pending;
         if (enable && any_btn_c && (req_c != dir_opposite(committed)))
            pending <= req_c;
      end
   end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game state: movement on tick, growth, self-collision and per-cell render queries.
module snake_move_ctrl
   import game_pkg::*;
#(
   parameter int unsigned MAX_LEN  = 16,
   parameter int unsigned INIT_LEN = 3
) (
   input  logic               in_clk,
   input  logic               rst,
   input  logic               upd_tick,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               grow,
   input  logic [COORD_W-1:0] x_in,
   input  logic [COORD_W-1:0] y_in,
   output logic [COORD_W-1:0] head_x,
   output logic [COORD_W-1:0] head_y,
   output logic [LEN_W-1:0]   length,
   output logic               pix_is_head,
   output logic               pix_is_body,
   output logic               game_over,
   output logic [1:0]         play_state
);

   play_state_t       state_q, state_d;
   cell_t             seg_q [MAX_LEN];
   logic [LEN_W-1:0]  len_q;
   logic              grow_pending_q;
   dir_t              pending, committed;
   logic              any_btn;
   logic              commit, reload, do_move, hit, grow_eff;
   cell_t             nxt, query;
   logic              head_match, body_match;

   snake_dir_latch u_dir (
      .clk       (in_clk),
      .rst       (rst),
      .enable    (state_q != ST_DEAD),
      .commit    (commit),
      .reload    (reload),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .pending   (pending),
      .committed (committed),
      .any_btn_c (any_btn)
   );

   // Next head with explicit boundary wrap.
   always_comb begin
      nxt = seg_q[0];
      case (pending)
         DIR_UP:    nxt.y = (seg_q[0].y == '0) ? COORD_W'(GRID_H - 1) : seg_q[0].y - COORD_W'(1);
         DIR_DOWN:  nxt.y = (seg_q[0].y == COORD_W'(GRID_H - 1)) ? '0 : seg_q[0].y + COORD_W'(1);
         DIR_LEFT:  nxt.x = (seg_q[0].x == '0) ? COORD_W'(GRID_W - 1) : seg_q[0].x - COORD_W'(1);
         default:   nxt.x = (seg_q[0].x == COORD_W'(GRID_W - 1)) ? '0 : seg_q[0].x + COORD_W'(1);
      endcase
   end

   // The tail vacates its cell unless the snake actually lengthens this tick.
   assign grow_eff = (grow_pending_q | grow) && (len_q < LEN_W'(MAX_LEN));

   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < len_q) && ((LEN_W'(i) != len_q - LEN_W'(1)) || grow_eff)
             && (seg_q[i] == nxt))
            hit = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      reload  = 1'b0;
      do_move = 1'b0;
      case (state_q)
         ST_IDLE: if (any_btn) state_d = ST_RUN;
         ST_RUN: begin
            if (upd_tick) begin
               commit = 1'b1;
               if (hit) state_d = ST_DEAD;
               else     do_move = 1'b1;
            end
         end
         ST_DEAD: begin
            if (any_btn) begin
               state_d = ST_IDLE;
               reload  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge in_clk) begin
      if (rst || reload) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (i < INIT_LEN) seg_q[i] <= '{x: COORD_W'(START_X - i), y: COORD_W'(START_Y)};
            else              seg_q[i] <= '0;
         end
         len_q          <= LEN_W'(INIT_LEN);
         grow_pending_q <= 1'b0;
      end else if (do_move) begin
         for (int unsigned i = 1; i < MAX_LEN; i++) seg_q[i] <= seg_q[i-1];
         seg_q[0]       <= nxt;
         grow_pending_q <= 1'b0;
         if (grow_eff) len_q <= len_q + LEN_W'(1);
      end else if (grow && (state_q != ST_DEAD) && !commit) begin
         grow_pending_q <= 1'b1;
      end
   end

   // Render query: head and active body match, only for in-grid cells.
   assign query = '{x: x_in, y: y_in};

   always_comb begin
      head_match = (x_in < COORD_W'(GRID_W)) && (y_in < COORD_W'(GRID_H)) && (seg_q[0] == query);
      body_match = 1'b0;
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
         if ((LEN_W'(i) < len_q) && (seg_q[i] == query)) body_match = 1'b1;
      end
      body_match = body_match && !head_match && (x_in < COORD_W'(GRID_W)) && (y_in < COORD_W'(GRID_H));
   end

   always_ff @(posedge in_clk) begin
      if (rst) begin
         pix_is_head <= 1'b0;
         pix_is_body <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         pix_is_head <= head_match;
         pix_is_body <= body_match;
         game_over   <= (state_d == ST_DEAD);
      end
   end

   assign head_x     = seg_q[0].x;
   assign head_y     = seg_q[0].y;
   assign length     = len_q;
   assign play_state = 2'(state_q);

endmodule
